// File: rtl/music_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : music_control_unit
// Brief    : Playback controller that turns button and song-done rising edges
//            into a play enable, a one-cycle player restart pulse and a song index.
// Revision : 1.0 - initial release
// ============================================================================
module music_control_unit #(
    parameter int SONG_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 play_button,
    input  logic                 next_button,
    input  logic                 song_done,
    output logic                 play,
    output logic                 reset_player,
    output logic [SONG_BITS-1:0] song
);

    localparam logic [SONG_BITS-1:0] c_song_one = SONG_BITS'(1);

    typedef enum logic [1:0] {
        ST_PAUSED  = 2'b00,
        ST_PLAYING = 2'b01,
        ST_NEXT    = 2'b10
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_play_hist;
    logic                 r_next_hist;
    logic                 r_done_hist;
    logic                 w_play_evt;
    logic                 w_next_evt;
    logic                 w_done_evt;
    logic                 w_song_inc;
    logic [SONG_BITS-1:0] r_song;
    logic                 r_play;
    logic                 r_reset_player;

    assign w_play_evt = play_button & ~r_play_hist;
    assign w_next_evt = next_button & ~r_next_hist;
    assign w_done_evt = song_done   & ~r_done_hist;

    // History flops track inputs in every state, so events seen during NEXT
    // are consumed rather than deferred.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_play_hist <= 1'b0;
            r_next_hist <= 1'b0;
            r_done_hist <= 1'b0;
        end else begin
            r_play_hist <= play_button;
            r_next_hist <= next_button;
            r_done_hist <= song_done;
        end
    end

    always_comb begin
        w_state_next = ST_PAUSED;
        w_song_inc   = 1'b0;
        case (r_state)
            ST_PAUSED: begin
                w_state_next = ST_PAUSED;
                if (w_next_evt) begin
                    w_state_next = ST_NEXT;
                    w_song_inc   = 1'b1;
                end else if (w_play_evt) begin
                    w_state_next = ST_PLAYING;
                end
            end
            ST_PLAYING: begin
                w_state_next = ST_PLAYING;
                if (w_next_evt || w_done_evt) begin
                    w_state_next = ST_NEXT;
                    w_song_inc   = 1'b1;
                end else if (w_play_evt) begin
                    w_state_next = ST_PAUSED;
                end
            end
            ST_NEXT: begin
                w_state_next = ST_PAUSED;
            end
            default: begin
                w_state_next = ST_PAUSED;
            end
        endcase
    end

    // Outputs are decoded from the next state so they leave the flops
    // together with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_PAUSED;
            r_song         <= '0;
            r_play         <= 1'b0;
            r_reset_player <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_play         <= (w_state_next == ST_PLAYING);
            r_reset_player <= (w_state_next == ST_NEXT);
            if (w_song_inc) begin
                r_song <= r_song + c_song_one;
            end
        end
    end

    assign play         = r_play;
    assign reset_player = r_reset_player;
    assign song         = r_song;

endmodule
`default_nettype wire

// File: tb/tb_music_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_music_control_unit
// Brief    : Directed vector bench for music_control_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_music_control_unit;

    localparam int SONG_BITS = 2;

    logic                 clk;
    logic                 reset;
    logic                 play_button;
    logic                 next_button;
    logic                 song_done;
    logic                 play;
    logic                 reset_player;
    logic [SONG_BITS-1:0] song;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic                 pb;
        logic                 nb;
        logic                 sd;
        logic                 exp_play;
        logic                 exp_rp;
        logic [SONG_BITS-1:0] exp_song;
    } vec_t;

    vec_t vecs[$];

    music_control_unit #(.SONG_BITS(SONG_BITS)) dut (
        .clk          (clk),
        .reset        (reset),
        .play_button  (play_button),
        .next_button  (next_button),
        .song_done    (song_done),
        .play         (play),
        .reset_player (reset_player),
        .song         (song)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int idx, input logic ep, input logic erp,
                              input logic [SONG_BITS-1:0] es);
        check({tag, ".play"}, idx, {7'd0, play}, {7'd0, ep});
        check({tag, ".reset_player"}, idx, {7'd0, reset_player}, {7'd0, erp});
        check({tag, ".song"}, idx, 8'(song), 8'(es));
    endtask

    task automatic add(input logic pb, input logic nb, input logic sd,
                       input logic ep, input logic erp, input logic [SONG_BITS-1:0] es);
        vec_t v;
        v.pb = pb; v.nb = nb; v.sd = sd;
        v.exp_play = ep; v.exp_rp = erp; v.exp_song = es;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Inputs: pb nb sd | expected after the edge: play rp song
        add(1,0,0, 1,0,2'd0);  // play press -> PLAYING
        add(0,0,0, 1,0,2'd0);
        add(1,0,0, 0,0,2'd0);  // play press -> PAUSED, song kept
        add(0,0,0, 0,0,2'd0);
        add(1,0,0, 1,0,2'd0);
        add(0,0,0, 1,0,2'd0);
        add(0,0,1, 0,1,2'd1);  // song_done held 5 cycles -> one NEXT
        add(0,0,1, 0,0,2'd1);
        add(0,0,1, 0,0,2'd1);
        add(0,0,1, 0,0,2'd1);
        add(0,0,1, 0,0,2'd1);
        add(0,0,0, 0,0,2'd1);
        add(0,1,0, 0,1,2'd2);  // next pulses: 2,3,0(wrap),1
        add(0,0,0, 0,0,2'd2);
        add(0,0,0, 0,0,2'd2);
        add(0,1,0, 0,1,2'd3);
        add(0,0,0, 0,0,2'd3);
        add(0,0,0, 0,0,2'd3);
        add(0,1,0, 0,1,2'd0);
        add(0,0,0, 0,0,2'd0);
        add(0,0,0, 0,0,2'd0);
        add(0,1,0, 0,1,2'd1);
        add(0,0,0, 0,0,2'd1);
        add(0,0,0, 0,0,2'd1);
        add(1,1,0, 0,1,2'd2);  // play+next together: next wins, play discarded
        add(1,0,0, 0,0,2'd2);
        add(1,0,0, 0,0,2'd2);
        add(0,0,0, 0,0,2'd2);
        add(1,0,0, 1,0,2'd2);  // play held 3 cycles -> single toggle
        add(1,0,0, 1,0,2'd2);
        add(1,0,0, 1,0,2'd2);
        add(0,0,0, 1,0,2'd2);
        add(0,1,0, 0,1,2'd3);  // play event inside NEXT is ignored
        add(1,0,0, 0,0,2'd3);
        add(0,0,0, 0,0,2'd3);
        add(1,0,0, 1,0,2'd3);
        add(0,0,0, 1,0,2'd3);
        add(0,1,1, 0,1,2'd0);  // next+done together: single increment, wraps
        add(0,0,0, 0,0,2'd0);
        add(0,0,1, 0,0,2'd0);  // song_done while PAUSED is ignored
        add(0,0,0, 0,0,2'd0);
        add(1,0,0, 1,0,2'd0);
        add(0,0,0, 1,0,2'd0);
        add(0,1,0, 0,1,2'd1);
        add(0,0,0, 0,0,2'd1);
        add(0,1,0, 0,1,2'd2);
        add(0,0,0, 0,0,2'd2);
        add(1,0,0, 1,0,2'd2);  // PLAYING with song=2 for the reset test
        add(0,0,0, 1,0,2'd2);

        reset       = 1'b0;
        play_button = 1'b0;
        next_button = 1'b0;
        song_done   = 1'b0;
        #1;
        check_outs("async_reset_init", 0, 1'b0, 1'b0, 2'd0);
        step();
        step();
        #2;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_outs("idle", i, 1'b0, 1'b0, 2'd0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            play_button = vecs[i].pb;
            next_button = vecs[i].nb;
            song_done   = vecs[i].sd;
            step();
            check_outs("vec", i, vecs[i].exp_play, vecs[i].exp_rp, vecs[i].exp_song);
        end

        // Asynchronous reset mid-cycle while PLAYING with song=2.
        #2;
        reset = 1'b0;
        #1;
        check_outs("mid_reset", 0, 1'b0, 1'b0, 2'd0);
        step();
        check_outs("reset_held", 0, 1'b0, 1'b0, 2'd0);

        // Release with play already held: the first edge counts as a press.
        play_button = 1'b1;
        #2;
        reset = 1'b1;
        step();
        check_outs("held_after_reset", 0, 1'b1, 1'b0, 2'd0);
        step();
        check_outs("held_after_reset", 1, 1'b1, 1'b0, 2'd0);

        // Reset during NEXT clears reset_player and song immediately.
        play_button = 1'b0;
        next_button = 1'b1;
        step();
        check_outs("next_before_reset", 0, 1'b0, 1'b1, 2'd1);
        #2;
        reset = 1'b0;
        #1;
        check_outs("reset_in_next", 0, 1'b0, 1'b0, 2'd0);
        next_button = 1'b0;
        #2;
        reset = 1'b1;
        step();
        check_outs("after_next_reset", 0, 1'b0, 1'b0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
